// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: grants one of four requesters round-robin and scans its
// serial lane for one frame of FRAME_LEN valid bits. An overlapping 11011
// detector counts matches (saturating). A report carries the frame owner and
// its hit count. This happens at normal completion or when the owner withdraws.
// Optional feature: define SEQ_ARB_TIMEOUT_EN to abort a frame after TIMEOUT
// consecutive SCAN cycles without din_valid.
module seq_scan_arbiter #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       req,
    input  logic [3:0]       din,
    input  logic             din_valid,
    output logic [3:0]       gnt,
    output logic             busy,
    output logic             Z,
    output logic             done,
    output logic             abort,
    output logic [1:0]       done_id,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_REPORT} state_t;
    typedef enum logic [2:0] {D_INIT, D_S1, D_S11, D_S110, D_S1101, D_MATCH} det_t;

    localparam logic [7:0]       LAST_BIT = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HIT_MAX  = '1;

    state_t           r_state, w_state_next;
    det_t             r_det, w_det_next, w_det_step;
    logic [7:0]       r_bit_cnt, w_bit_cnt_next;
    logic [CNT_W-1:0] r_hit, w_hit_next, w_hit_step;
    logic [1:0]       r_owner, w_owner_next;
    logic [1:0]       r_last_owner, w_last_owner_next;
    logic [3:0]       r_gnt, w_gnt_next;
    logic             r_done, w_done_next;
    logic             r_abort, w_abort_next;
    logic [1:0]       r_done_id, w_done_id_next;
    logic [CNT_W-1:0] r_hit_cnt, w_hit_cnt_next;

    logic             w_lane_bit;
    logic             w_timeout;
    logic [1:0]       w_cand_idx [4];
    logic [3:0]       w_cand_req;
    logic [1:0]       w_pick;

    // One step of the overlapping 11011 detector.
    function automatic det_t det_step(input det_t s, input logic b);
        det_t n;
        case (s)
            D_INIT:  n = b ? D_S1    : D_INIT;
            D_S1:    n = b ? D_S11   : D_INIT;
            D_S11:   n = b ? D_S11   : D_S110;
            D_S110:  n = b ? D_S1101 : D_INIT;
            D_S1101: n = b ? D_MATCH : D_INIT;
            D_MATCH: n = b ? D_S11   : D_S110;
            default: n = D_INIT;
        endcase
        return n;
    endfunction

    // Candidate order for round-robin: last_owner+1, +2, +3, +4 (mod 4).
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign w_cand_idx[gi] = r_last_owner + 2'(gi + 1);
        assign w_cand_req[gi] = req[w_cand_idx[gi]];
    end

    // Earliest requesting candidate in round-robin order wins.
    always_comb begin
        w_pick = w_cand_idx[0];
        for (int i = 3; i >= 0; i--) begin
            if (w_cand_req[i]) begin
                w_pick = w_cand_idx[i];
            end
        end
    end

    assign w_lane_bit = din[r_owner];
    assign w_det_step = det_step(r_det, w_lane_bit);
    assign w_hit_step = (w_det_step == D_MATCH && r_hit != HIT_MAX) ? r_hit + 1'b1 : r_hit;

`ifdef SEQ_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_idle_cnt, w_idle_cnt_next;

    assign w_idle_cnt_next = (r_state == ST_SCAN && !din_valid) ? r_idle_cnt + 1'b1 : '0;
    assign w_timeout = (r_state == ST_SCAN) && !din_valid && (r_idle_cnt == TW'(TIMEOUT - 1));

    // Consecutive idle-bit counter for the watchdog.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= w_idle_cnt_next;
        end
    end
`else
    // Watchdog not built: constant false for any legal TIMEOUT.
    assign w_timeout = (TIMEOUT < 0);
`endif

    // Control FSM next-state and registered-output logic.
    always_comb begin
        w_state_next      = r_state;
        w_det_next        = r_det;
        w_bit_cnt_next    = r_bit_cnt;
        w_hit_next        = r_hit;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_gnt_next        = r_gnt;
        w_done_next       = 1'b0;
        w_abort_next      = 1'b0;
        w_done_id_next    = r_done_id;
        w_hit_cnt_next    = r_hit_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_next      = ST_SCAN;
                    w_owner_next      = w_pick;
                    w_last_owner_next = w_pick;
                    w_gnt_next        = 4'b0001 << w_pick;
                    w_det_next        = D_INIT;
                    w_bit_cnt_next    = '0;
                    w_hit_next        = '0;
                end
            end
            ST_SCAN: begin
                if (!req[r_owner] || w_timeout) begin
                    // Owner withdrew (or lane went silent): drop any bit this cycle.
                    w_state_next   = ST_IDLE;
                    w_gnt_next     = 4'b0000;
                    w_abort_next   = 1'b1;
                    w_done_id_next = r_owner;
                    w_hit_cnt_next = r_hit;
                end else if (din_valid) begin
                    w_det_next = w_det_step;
                    w_hit_next = w_hit_step;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next   = ST_REPORT;
                        w_gnt_next     = 4'b0000;
                        w_done_next    = 1'b1;
                        w_done_id_next = r_owner;
                        w_hit_cnt_next = w_hit_step;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 8'd1;
                    end
                end
            end
            ST_REPORT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = 4'b0000;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_det        <= D_INIT;
            r_bit_cnt    <= '0;
            r_hit        <= '0;
            r_owner      <= 2'd0;
            r_last_owner <= 2'd3;
            r_gnt        <= 4'b0000;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
            r_done_id    <= 2'd0;
            r_hit_cnt    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_det        <= w_det_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_hit        <= w_hit_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_gnt        <= w_gnt_next;
            r_done       <= w_done_next;
            r_abort      <= w_abort_next;
            r_done_id    <= w_done_id_next;
            r_hit_cnt    <= w_hit_cnt_next;
        end
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state == ST_SCAN);
    assign Z       = (r_det == D_MATCH);
    assign done    = r_done;
    assign abort   = r_abort;
    assign done_id = r_done_id;
    assign hit_cnt = r_hit_cnt;

endmodule
